// File: rtl/qsys_ram_pkg.sv
// Shared constants, geometry helpers and capture-mode type for the capture RAM.
// Build option: QSYS_CAPTURE_RAM_OUTREG_EN is handled by qsys_system_capture_ram.
package qsys_ram_pkg;

  localparam int RD_LAT_BASE   = 1;
  localparam int RD_LAT_OUTREG = 2;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    RING     = 1'b1
  } cap_mode_e;

  // Width of the capture channel select, never narrower than one bit.
  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int calc_seg(input int addr_w, input int num_ch);
    return (1 << addr_w) / num_ch;
  endfunction

  // Write pointer width: the low address bits inside one channel segment.
  function automatic int calc_ptr_w(input int addr_w, input int num_ch);
    return addr_w - $clog2(num_ch);
  endfunction

endpackage

// File: rtl/qsys_capture_ram_chan_ptr.sv
// Per-channel capture bookkeeping: segment write pointer, done flag, the
// one-shot stop condition and the overrun request for dropped samples.
module qsys_capture_ram_chan_ptr
  import qsys_ram_pkg::*;
#(
  parameter int        PTR_W = 7,
  parameter cap_mode_e MODE  = ONE_SHOT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             hit,
  output logic [PTR_W-1:0] wrptr,
  output logic             done,
  output logic             wr_en,
  output logic             overrun_req
);

  logic stopped;

  // A one-shot channel stops taking samples once its segment has filled.
  assign stopped     = (MODE == ONE_SHOT) && done;
  assign wr_en       = hit && !stopped;
  assign overrun_req = hit && stopped;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrptr <= '0;
      done  <= 1'b0;
    end else if (arm) begin
      wrptr <= '0;
      done  <= 1'b0;
    end else if (wr_en) begin
      wrptr <= wrptr + PTR_W'(1);
      if (&wrptr) done <= 1'b1;
    end
  end

endmodule

// File: rtl/qsys_system_capture_ram.sv
// Dual-access capture RAM: Avalon-MM s1 slave plus streaming sample capture.
// Define QSYS_CAPTURE_RAM_OUTREG_EN for a registered s1_readdata (latency 2).
module qsys_system_capture_ram
  import qsys_ram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int NUM_CH     = 8,
  parameter int CONTINUOUS = 0,
  localparam int CH_W      = calc_ch_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic                cap_arm,
  input  logic                cap_stop,
  input  logic                cap_valid,
  input  logic [CH_W-1:0]     cap_chan,
  input  logic [DATA_W-1:0]   cap_data,
  output logic                cap_busy,
  output logic [NUM_CH-1:0]   cap_done,
  output logic                cap_overrun
);

  localparam int        BYTES = DATA_W / 8;
  localparam int        DEPTH = 1 << ADDR_W;
  localparam int        PTR_W = calc_ptr_w(ADDR_W, NUM_CH);
  localparam cap_mode_e MODE  = (CONTINUOUS != 0) ? RING : ONE_SHOT;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              arm, stop, cap_en, cap_wr, s1_wr, s1_rd;
  logic [CH_W-1:0]   chan_idx;
  logic [ADDR_W-1:0] cap_addr;
  logic [PTR_W-1:0]  wrptr [NUM_CH];
  logic [NUM_CH-1:0] hit, wr_en, ovr_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  assign arm    = cap_arm && clken;
  assign stop   = cap_stop && clken;
  assign cap_en = cap_busy && cap_valid && clken && !arm;
  assign s1_wr  = s1_chipselect && s1_write && clken;
  assign s1_rd  = s1_chipselect && s1_read && clken && !s1_write;

  // With a single channel every sample lands in the one segment.
  assign chan_idx = (NUM_CH == 1) ? '0 : cap_chan;
  assign cap_addr = (ADDR_W'(chan_idx) << PTR_W) | ADDR_W'(wrptr[chan_idx]);
  assign cap_wr   = |wr_en;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    assign hit[c] = cap_en && (chan_idx == CH_W'(c));

    qsys_capture_ram_chan_ptr #(
      .PTR_W (PTR_W),
      .MODE  (MODE)
    ) u_ptr (
      .clk         (clk),
      .reset       (reset),
      .arm         (arm),
      .hit         (hit[c]),
      .wrptr       (wrptr[c]),
      .done        (cap_done[c]),
      .wr_en       (wr_en[c]),
      .overrun_req (ovr_req[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_busy    <= 1'b0;
      cap_overrun <= 1'b0;
    end else begin
      if (arm)                                     cap_busy <= 1'b1;
      else if (stop || (MODE == ONE_SHOT && &cap_done)) cap_busy <= 1'b0;

      if (arm)           cap_overrun <= 1'b0;
      else if (|ovr_req) cap_overrun <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset branch; clearing thousands of words
  // would stop it mapping onto block RAM, and its contents are undefined anyway.
  always_ff @(posedge clk) begin
    if (cap_wr) mem[cap_addr] <= cap_data;
    // A capture to the same word takes priority and drops the whole s1 write.
    if (s1_wr && !(cap_wr && cap_addr == s1_address)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s1_byteenable[b]) mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
      end
    end
  end

  // Read stage samples the pre-edge word, so a same-cycle write returns old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= s1_rd;
      if (s1_rd) rd_data <= mem[s1_address];
    end
  end

`ifdef QSYS_CAPTURE_RAM_OUTREG_EN
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_valid;
      if (rd_valid) out_data <= rd_data;
    end
  end

  assign s1_readdata      = out_data;
  assign s1_readdatavalid = out_valid;
`else
  assign s1_readdata      = rd_data;
  assign s1_readdatavalid = rd_valid;
`endif

endmodule
